// File: rtl/dispather_cpuid_mgr.sv
// dispather_cpuid_mgr: allocates a CPU thread id to each dispatcher request.
// Round robin over enabled threads whose pending count is below a threshold.
// Optional feature macro CPUID_KEY_AFFINITY_EN: start the search at the flow
// key instead of the round-robin pointer.
module dispather_cpuid_mgr #(
    parameter int unsigned THREAD_NUM    = 32,
    parameter logic [3:0]  RST_THRESHOLD = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_cpuid_ctl,
    input  logic [4:0]  in_cpuid_key,
    output logic [4:0]  out_cpuid,
    output logic        out_cpuid_ack,
    output logic        out_cpuid_valid,
    input  logic        in_release_wr,
    input  logic [4:0]  in_release_cpuid,
    input  logic        in_cfg_wr,
    input  logic [31:0] in_cfg_mask,
    input  logic [3:0]  in_cfg_threshold,
    output logic        out_release_err
);

    localparam int unsigned MAX_THREADS = 32;
    localparam int unsigned ID_W        = 5;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SWEEP_W     = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        GRANT  = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         cand_q, cand_d;
    logic [SWEEP_W-1:0]      sweep_q, sweep_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         cpuid_q, cpuid_d;
    logic                    ack_q, ack_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [MAX_THREADS-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]        thr_q, thr_d;
    logic [CNT_W-1:0]        cnt_q [MAX_THREADS];
    logic [CNT_W-1:0]        cnt_d [MAX_THREADS];

    logic                    elig_c;
    logic                    grant_c;
    logic [ID_W-1:0]         start_c;

    // Next candidate id, wrapping from THREAD_NUM-1 back to 0
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (32'(id) >= THREAD_NUM - 1) ? '0 : id + ID_W'(1);
    endfunction

    // First candidate of a new search
`ifdef CPUID_KEY_AFFINITY_EN
    assign start_c = ID_W'(32'(in_cpuid_key) % THREAD_NUM);
`else
    logic unused_key_c;
    assign unused_key_c = ^in_cpuid_key;
    assign start_c      = rr_ptr_q;
`endif

    // Current candidate may take another packet
    assign elig_c = (32'(cand_q) < THREAD_NUM) && mask_q[cand_q] && (cnt_q[cand_q] < thr_q);

    // Allocation FSM: next state and result registers
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        sweep_d  = sweep_q;
        rr_ptr_d = rr_ptr_q;
        cpuid_d  = cpuid_q;
        valid_d  = valid_q;
        ack_d    = ack_q;
        grant_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (in_cpuid_ctl) begin
                    cand_d  = start_c;
                    sweep_d = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (elig_c) begin
                    cpuid_d = cand_q;
                    valid_d = 1'b1;
                    grant_c = 1'b1;
`ifndef CPUID_KEY_AFFINITY_EN
                    rr_ptr_d = next_id(cand_q);
`endif
                    ack_d   = 1'b1;
                    state_d = GRANT;
                end else if (sweep_q == SWEEP_W'(THREAD_NUM - 1)) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = GRANT;
                end else begin
                    cand_d  = next_id(cand_q);
                    sweep_d = sweep_q + SWEEP_W'(1);
                end
            end
            GRANT: begin
                // A request withdrawn during the search gets a one-cycle ack
                ack_d   = in_cpuid_ctl;
                state_d = in_cpuid_ctl ? HOLD : IDLE;
            end
            HOLD: begin
                if (!in_cpuid_ctl) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending counters: grant increments, release decrements, both cancel
    always_comb begin
        err_d = err_q;
        if (in_release_wr &&
            ((32'(in_release_cpuid) >= THREAD_NUM) || (cnt_q[in_release_cpuid] == '0))) begin
            err_d = 1'b1;
        end
        for (int unsigned i = 0; i < MAX_THREADS; i++) begin
            logic inc, dec;
            cnt_d[i] = cnt_q[i];
            inc = grant_c && (cand_q == ID_W'(i));
            dec = in_release_wr && (in_release_cpuid == ID_W'(i)) &&
                  (i < THREAD_NUM) && (cnt_q[i] != '0);
            if (inc && !dec && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Configuration registers
    always_comb begin
        mask_d = mask_q;
        thr_d  = thr_q;
        if (in_cfg_wr) begin
            mask_d = in_cfg_mask;
            thr_d  = in_cfg_threshold;
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            sweep_q  <= '0;
            rr_ptr_q <= '0;
            cpuid_q  <= '0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            mask_q   <= '1;
            thr_q    <= RST_THRESHOLD;
            for (int unsigned i = 0; i < MAX_THREADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            sweep_q  <= sweep_d;
            rr_ptr_q <= rr_ptr_d;
            cpuid_q  <= cpuid_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            thr_q    <= thr_d;
            for (int unsigned i = 0; i < MAX_THREADS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_cpuid       = cpuid_q;
    assign out_cpuid_ack   = ack_q;
    assign out_cpuid_valid = valid_q;
    assign out_release_err = err_q;

endmodule

// File: tb/tb_dispather_cpuid_mgr.sv
// Directed-vector bench for dispather_cpuid_mgr (THREAD_NUM = 32).
module tb_dispather_cpuid_mgr;

    logic        clk;
    logic        rst_n;
    logic        ctl;
    logic [4:0]  key;
    logic [4:0]  cpuid;
    logic        ack;
    logic        valid;
    logic        rel_wr;
    logic [4:0]  rel_id;
    logic        cfg_wr;
    logic [31:0] cfg_mask;
    logic [3:0]  cfg_thr;
    logic        rel_err;

    int n_vec = 0;
    int n_err = 0;

    dispather_cpuid_mgr #(.THREAD_NUM(32), .RST_THRESHOLD(4'd8)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .in_cpuid_ctl     (ctl),
        .in_cpuid_key     (key),
        .out_cpuid        (cpuid),
        .out_cpuid_ack    (ack),
        .out_cpuid_valid  (valid),
        .in_release_wr    (rel_wr),
        .in_release_cpuid (rel_id),
        .in_cfg_wr        (cfg_wr),
        .in_cfg_mask      (cfg_mask),
        .in_cfg_threshold (cfg_thr),
        .out_release_err  (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise ctl, wait for ack (bounded), hold ctl for 'hold' cycles, drop it
    task automatic request(input int hold, output int lat, output logic [4:0] id, output logic v);
        @(negedge clk);
        ctl = 1'b1;
        lat = 0;
        while (!ack && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("ack_timeout", 32'(lat), 32'd0);
        id = cpuid;
        v  = valid;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ack", 32'(ack), 32'd1);
            check("hold_id", 32'(cpuid), 32'(id));
        end
        ctl = 1'b0;
        @(negedge clk);
        check("ack_drop", 32'(ack), 32'd0);
    endtask

    task automatic release_id(input logic [4:0] id);
        @(negedge clk);
        rel_wr = 1'b1;
        rel_id = id;
        @(negedge clk);
        rel_wr = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] m, input logic [3:0] t);
        @(negedge clk);
        cfg_wr   = 1'b1;
        cfg_mask = m;
        cfg_thr  = t;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    int         lat;
    logic [4:0] id;
    logic       v;
    int         exp_ids [3] = '{0, 1, 2};

    initial begin
        rst_n = 1'b0; ctl = 1'b0; key = 5'd0; rel_wr = 1'b0; rel_id = 5'd0;
        cfg_wr = 1'b0; cfg_mask = '0; cfg_thr = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_cpuid", 32'(cpuid), 32'd0);
        check("rst_err", 32'(rel_err), 32'd0);
        rst_n = 1'b1;

        // Three round-robin requests with ctl held past ack
        for (int r = 0; r < 3; r++) begin
            request(3, lat, id, v);
            check("rr_id", 32'(id), 32'(exp_ids[r]));
            check("rr_valid", 32'(v), 32'd1);
            check("rr_lat", 32'(lat), 32'd2);
        end
        for (int t = 0; t < 3; t++) check("rr_cnt", 32'(dut.cnt_q[t]), 32'd1);
        check("rr_cnt3", 32'(dut.cnt_q[3]), 32'd0);

        // Drain threads 0..2
        for (int t = 0; t < 3; t++) release_id(5'(t));
        for (int t = 0; t < 3; t++) check("rel_cnt", 32'(dut.cnt_q[t]), 32'd0);
        check("rel_err0", 32'(rel_err), 32'd0);

        // Mask 0x5, threshold 1, rr_ptr = 3
        cfg(32'h0000_0005, 4'd1);
        request(0, lat, id, v);
        check("m5_id_a", 32'(id), 32'd0);
        check("m5_valid_a", 32'(v), 32'd1);
        check("m5_lat_a", 32'(lat), 32'd31);
        request(1, lat, id, v);
        check("m5_id_b", 32'(id), 32'd2);
        check("m5_lat_b", 32'(lat), 32'd3);
        request(1, lat, id, v);
        check("m5_valid_c", 32'(v), 32'd0);
        check("m5_lat_c", 32'(lat), 32'd33);
        check("m5_id_c", 32'(id), 32'd2);
        check("m5_cnt0", 32'(dut.cnt_q[0]), 32'd1);
        check("m5_cnt2", 32'(dut.cnt_q[2]), 32'd1);

        // Only thread 5 enabled; rr_ptr = 3 -> grant 5 after three candidates
        cfg(32'h0000_0020, 4'd8);
        request(0, lat, id, v);
        check("t5_id", 32'(id), 32'd5);
        check("t5_lat", 32'(lat), 32'd4);
        check("t5_cnt", 32'(dut.cnt_q[5]), 32'd1);

        // rr_ptr = 6: grant to 5 lands on the 33rd edge; release 5 on that edge
        @(negedge clk);
        ctl = 1'b1;
        repeat (32) @(negedge clk);
        check("pre_grant_ack", 32'(ack), 32'd0);
        rel_wr = 1'b1;
        rel_id = 5'd5;
        @(negedge clk);
        rel_wr = 1'b0;
        check("same_ack", 32'(ack), 32'd1);
        check("same_id", 32'(cpuid), 32'd5);
        check("same_cnt5", 32'(dut.cnt_q[5]), 32'd1);
        ctl = 1'b0;
        @(negedge clk);

        // Release on an idle thread sets the sticky error
        release_id(5'd7);
        check("err_set", 32'(rel_err), 32'd1);
        check("err_cnt7", 32'(dut.cnt_q[7]), 32'd0);
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(rel_err), 32'd1);

        // Reset mid-SEARCH (long search from rr_ptr 6 to thread 5)
        @(negedge clk);
        ctl = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_ack0", 32'(ack), 32'd0);
        #2 rst_n = 1'b0;
        ctl = 1'b0;
        #1;
        check("rst_async_err", 32'(rel_err), 32'd0);
        check("rst_async_ack", 32'(ack), 32'd0);
        check("rst_cnt0", 32'(dut.cnt_q[0]), 32'd0);
        check("rst_cnt5", 32'(dut.cnt_q[5]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        request(0, lat, id, v);
        check("post_rst_id", 32'(id), 32'd0);
        check("post_rst_valid", 32'(v), 32'd1);
        check("post_rst_lat", 32'(lat), 32'd2);

        // Threshold 0 and ctl withdrawn during SEARCH: one-cycle ack, valid 0
        cfg(32'hFFFF_FFFF, 4'd0);
        @(negedge clk);
        ctl = 1'b1;
        @(negedge clk);
        ctl = 1'b0;
        lat = 1;
        while (!ack && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("thr0_lat", 32'(lat), 32'd33);
        check("thr0_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("thr0_ack_pulse", 32'(ack), 32'd0);
        check("thr0_cnt1", 32'(dut.cnt_q[1]), 32'd0);

        // Restore threshold: round robin resumes at thread 1
        cfg(32'hFFFF_FFFF, 4'd8);
        request(2, lat, id, v);
        check("resume_id", 32'(id), 32'd1);
        check("resume_cnt1", 32'(dut.cnt_q[1]), 32'd1);

`ifdef CPUID_KEY_AFFINITY_EN
        // Key 7 with thread 7 at threshold -> grant 8, rr_ptr unchanged
        cfg(32'hFFFF_FFFF, 4'd1);
        key = 5'd7;
        request(0, lat, id, v);
        check("aff_id7", 32'(id), 32'd7);
        request(0, lat, id, v);
        check("aff_id8", 32'(id), 32'd8);
        check("aff_valid", 32'(v), 32'd1);
        check("aff_rr", 32'(dut.rr_ptr_q), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
